// File: rtl/write_back_bank_pkg.sv
// Shared helpers for the write-back register bank: derived widths used by the
// interface, the top level and the per-channel staging registers.
package write_back_bank_pkg;

    function automatic int be_w(input int width);
        return width / 8;
    endfunction

    // Keep at least one address bit so a degenerate DEPTH still elaborates.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/write_back_bank_if.sv
// Write/read bus of the write-back register bank; master drives writes, clear
// and read indices, slave (the bank) returns read data, valid flags and status.
interface write_back_bank_if
    import write_back_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 2,
    parameter int NUM_RD = 2
) ();
    localparam int BE_W = be_w(WIDTH);
    localparam int AW   = addr_w(DEPTH);
    localparam int CW   = count_w(DEPTH);

    logic                     clr;
    logic [NUM_CH-1:0]        wr_en;
    logic [NUM_CH*AW-1:0]     wr_addr;
    logic [NUM_CH*WIDTH-1:0]  wr_data;
    logic [NUM_CH*BE_W-1:0]   wr_be;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*WIDTH-1:0]  rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic [CW-1:0]            valid_count;
    logic                     conflict;

    modport master (
        output clr, wr_en, wr_addr, wr_data, wr_be, rd_addr,
        input  rd_data, rd_valid, valid_count, conflict
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, wr_be, rd_addr,
        output rd_data, rd_valid, valid_count, conflict
    );

endinterface

// File: rtl/write_back_bank_stage.sv
// One write channel's staging register: holds a captured write for exactly one
// cycle; clear or a lost collision prevents capture.
module write_back_stage
    import write_back_bank_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      req,
    input  logic                      drop,
    input  logic [AW-1:0]             addr,
    input  logic [WIDTH-1:0]          data,
    input  logic [be_w(WIDTH)-1:0]    be,
    output logic                      vld_q,
    output logic [AW-1:0]             addr_q,
    output logic [WIDTH-1:0]          data_q,
    output logic [be_w(WIDTH)-1:0]    be_q
);
    localparam int BE_W = be_w(WIDTH);

    typedef struct packed {
        logic              vld;
        logic [AW-1:0]     addr;
        logic [WIDTH-1:0]  data;
        logic [BE_W-1:0]   be;
    } stage_t;

    stage_t stage_q;
    logic   capture;

    assign capture = req && !drop && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q.vld <= capture;
            if (capture) begin
                stage_q.addr <= addr;
                stage_q.data <= data;
                stage_q.be   <= be;
            end
        end
    end

    assign vld_q  = stage_q.vld;
    assign addr_q = stage_q.addr;
    assign data_q = stage_q.data;
    assign be_q   = stage_q.be;

endmodule

// File: rtl/write_back_bank.sv
// Multi-channel write-back register bank with byte enables, one-cycle staging
// and a valid bitmap. Define WRITE_BACK_BYPASS_EN to forward staged writes to reads.
module write_back_bank
    import write_back_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 2,
    parameter int NUM_RD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    write_back_bank_if.slave  bus
);
    localparam int BE_W = be_w(WIDTH);
    localparam int AW   = addr_w(DEPTH);
    localparam int CW   = count_w(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  bitmap;
    logic [CW-1:0]     valid_count_q;
    logic [CW-1:0]     pop;
    logic              conflict_q;
    logic              coll;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] stg_vld;
    logic [AW-1:0]     stg_addr [NUM_CH];
    logic [WIDTH-1:0]  stg_data [NUM_CH];
    logic [BE_W-1:0]   stg_be   [NUM_CH];
    logic [WIDTH-1:0]  commit_data [NUM_CH];

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] base,
                                               input logic [WIDTH-1:0] data,
                                               input logic [BE_W-1:0]  be);
        logic [WIDTH-1:0] r;
        r = base;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // A capturing channel loses to any higher-indexed channel aiming at the same entry.
    always_comb begin
        req  = '0;
        drop = '0;
        coll = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            req[c] = bus.wr_en[c] && (|bus.wr_be[c*BE_W +: BE_W])
                     && in_range(bus.wr_addr[c*AW +: AW]);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int d = c + 1; d < NUM_CH; d++) begin
                if (req[c] && req[d] && (bus.wr_addr[c*AW +: AW] == bus.wr_addr[d*AW +: AW])) begin
                    drop[c] = 1'b1;
                    coll    = 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stage
        write_back_stage #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (bus.clr),
            .req    (req[c]),
            .drop   (drop[c]),
            .addr   (bus.wr_addr[c*AW +: AW]),
            .data   (bus.wr_data[c*WIDTH +: WIDTH]),
            .be     (bus.wr_be[c*BE_W +: BE_W]),
            .vld_q  (stg_vld[c]),
            .addr_q (stg_addr[c]),
            .data_q (stg_data[c]),
            .be_q   (stg_be[c])
        );
    end

    // An invalid entry contributes zeros, so its non-enabled bytes are cleared on commit.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            commit_data[c] = merge(bitmap[stg_addr[c]] ? mem[stg_addr[c]] : '0,
                                   stg_data[c], stg_be[c]);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pop = pop + CW'(bitmap[i]);
        end
    end

    // Staged addresses are unique, so per-channel commits never collide here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bitmap        <= '0;
            valid_count_q <= '0;
            conflict_q    <= 1'b0;
        end else begin
            conflict_q    <= coll && !bus.clr;
            valid_count_q <= bus.clr ? '0 : pop;
            if (bus.clr) begin
                bitmap <= '0;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (stg_vld[c]) begin
                        mem[stg_addr[c]]    <= commit_data[c];
                        bitmap[stg_addr[c]] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.rd_data  = '0;
        bus.rd_valid = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] rdat;
            logic             rv;
            ra   = bus.rd_addr[p*AW +: AW];
            rdat = '0;
            rv   = 1'b0;
            if (in_range(ra)) begin
                rv   = bitmap[ra];
                rdat = rv ? mem[ra] : '0;
`ifdef WRITE_BACK_BYPASS_EN
                for (int c = 0; c < NUM_CH; c++) begin
                    if (stg_vld[c] && (stg_addr[c] == ra)) begin
                        rdat = merge(rdat, stg_data[c], stg_be[c]);
                        rv   = 1'b1;
                    end
                end
`endif
            end
            bus.rd_data[p*WIDTH +: WIDTH] = rdat;
            bus.rd_valid[p]               = rv;
        end
    end

    assign bus.valid_count = valid_count_q;
    assign bus.conflict    = conflict_q;

endmodule

// File: tb/tb_write_back_bank.sv
// Self-checking bench for write_back_bank: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the bank.
module tb_write_back_bank;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 2;
    localparam int NUM_RD = 2;
    localparam int AW     = 4;
    localparam int BE_W   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    write_back_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .NUM_RD(NUM_RD)) bus ();

    write_back_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .NUM_RD(NUM_RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    wr_t         m_pend [$];
    int          m_count;
    bit          m_conflict;

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end
        m_pend.delete();
        m_count    = 0;
        m_conflict = 1'b0;
    endfunction

    // What a reader should see at address a right now.
    function automatic void exp_read(input int a, output logic [31:0] d, output logic v);
        d = '0;
        v = 1'b0;
        if (a < DEPTH) begin
            v = m_vld[a];
            d = v ? m_mem[a] : 32'h0;
`ifdef WRITE_BACK_BYPASS_EN
            foreach (m_pend[k]) begin
                if (m_pend[k].addr == a) begin
                    d = apply_be(d, m_pend[k].data, m_pend[k].be);
                    v = 1'b1;
                end
            end
`endif
        end
    endfunction

    // Advance one clock: a write requested now becomes committed one edge after capture.
    task automatic clock_cycle();
        wr_t caps [$];
        bit  coll;
        int  cnt;
        coll = 1'b0;
        cnt  = 0;
        for (int i = 0; i < DEPTH; i++) cnt += m_vld[i];
        for (int c = 0; c < NUM_CH; c++) begin
            wr_t w;
            bit  found;
            w.addr = int'(bus.wr_addr[c*AW +: AW]);
            w.data = bus.wr_data[c*WIDTH +: WIDTH];
            w.be   = bus.wr_be[c*BE_W +: BE_W];
            found  = 1'b0;
            if (bus.wr_en[c] && w.be != 0 && w.addr < DEPTH) begin
                foreach (caps[k]) begin
                    if (caps[k].addr == w.addr) begin
                        caps[k] = w;
                        found   = 1'b1;
                        coll    = 1'b1;
                    end
                end
                if (!found) caps.push_back(w);
            end
        end
        @(posedge clk);
        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
            m_pend.delete();
            m_count    = 0;
            m_conflict = 1'b0;
        end else begin
            foreach (m_pend[k]) begin
                int a;
                a        = m_pend[k].addr;
                m_mem[a] = apply_be(m_vld[a] ? m_mem[a] : 32'h0, m_pend[k].data, m_pend[k].be);
                m_vld[a] = 1'b1;
            end
            m_count    = cnt;
            m_conflict = coll;
            m_pend     = caps;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr     = 1'b0;
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.rd_addr = {4'd1, 4'd0};
        rst_n = 1'b0;
        model_clear();
        #3;
        checks += 4;
        if (bus.rd_valid !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 00", bus.rd_valid);
        end
        if (bus.rd_data !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0", bus.rd_data);
        end
        if (bus.valid_count !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_valid_count: got %0d expected 0", bus.valid_count);
        end
        if (bus.conflict !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_conflict: got %b expected 0", bus.conflict);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: AW] = 4'd3;
        bus.wr_data[0 +: WIDTH] = 32'hDEADBEEF;
        bus.wr_be[0 +: BE_W] = 4'hF;
        bus.rd_addr[0 +: AW] = 4'd3;
        clock_cycle();
        idle_inputs();
        checks += 1;
`ifndef WRITE_BACK_BYPASS_EN
        if (bus.rd_valid[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL single_staged_valid: got %b expected 0", bus.rd_valid[0]);
        end
`else
        if (bus.rd_valid[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL single_staged_valid: got %b expected 1", bus.rd_valid[0]);
        end
`endif
        clock_cycle();
        checks += 3;
        if (bus.rd_data[0 +: WIDTH] !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL single_data: got %h expected deadbeef", bus.rd_data[0 +: WIDTH]);
        end
        if (bus.rd_valid[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL single_valid: got %b expected 1", bus.rd_valid[0]);
        end
        if (bus.valid_count !== 5'd0) begin
            errors++; $display("[TB] FAIL single_count_early: got %0d expected 0", bus.valid_count);
        end
        clock_cycle();
        checks += 1;
        if (bus.valid_count !== 5'd1) begin
            errors++; $display("[TB] FAIL single_count: got %0d expected 1", bus.valid_count);
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.wr_en = 2'b11;
        bus.wr_addr = {4'd5, 4'd5};
        bus.wr_data = {32'h22222222, 32'h11111111};
        bus.wr_be = 8'hFF;
        bus.rd_addr[0 +: AW] = 4'd5;
        clock_cycle();
        idle_inputs();
        checks += 1;
        if (bus.conflict !== 1'b1) begin
            errors++; $display("[TB] FAIL collision_pulse: got %b expected 1", bus.conflict);
        end
        clock_cycle();
        checks += 2;
        if (bus.conflict !== 1'b0) begin
            errors++; $display("[TB] FAIL collision_pulse_end: got %b expected 0", bus.conflict);
        end
        if (bus.rd_data[0 +: WIDTH] !== 32'h22222222) begin
            errors++; $display("[TB] FAIL collision_winner: got %h expected 22222222", bus.rd_data[0 +: WIDTH]);
        end
    endtask

    task automatic test_partial();
        do_reset();
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: AW] = 4'd7;
        bus.wr_data[0 +: WIDTH] = 32'hAAAABBBB;
        bus.wr_be[0 +: BE_W] = 4'h3;
        bus.rd_addr[NUM_RD*AW-AW +: AW] = 4'd7;
        clock_cycle();
        idle_inputs();
        clock_cycle();
        checks += 1;
        if (bus.rd_data[WIDTH +: WIDTH] !== 32'h0000BBBB) begin
            errors++; $display("[TB] FAIL partial_low: got %h expected 0000bbbb", bus.rd_data[WIDTH +: WIDTH]);
        end
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: AW] = 4'd7;
        bus.wr_data[0 +: WIDTH] = 32'hCCCC0000;
        bus.wr_be[0 +: BE_W] = 4'hC;
        clock_cycle();
        idle_inputs();
        clock_cycle();
        checks += 1;
        if (bus.rd_data[WIDTH +: WIDTH] !== 32'hCCCCBBBB) begin
            errors++; $display("[TB] FAIL partial_merge: got %h expected ccccbbbb", bus.rd_data[WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_clr();
        do_reset();
        bus.wr_en = 2'b10;
        bus.wr_addr[AW +: AW] = 4'd4;
        bus.wr_data[WIDTH +: WIDTH] = 32'h44444444;
        bus.wr_be[BE_W +: BE_W] = 4'hF;
        clock_cycle();
        idle_inputs();
        repeat (2) clock_cycle();
        checks += 1;
        if (bus.valid_count !== 5'd1) begin
            errors++; $display("[TB] FAIL clr_precount: got %0d expected 1", bus.valid_count);
        end
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: AW] = 4'd2;
        bus.wr_data[0 +: WIDTH] = 32'h12121212;
        bus.wr_be[0 +: BE_W] = 4'hF;
        clock_cycle();
        idle_inputs();
        bus.clr = 1'b1;
        bus.rd_addr = {4'd4, 4'd2};
        clock_cycle();
        bus.clr = 1'b0;
        checks += 3;
        if (bus.rd_valid !== 2'b00) begin
            errors++; $display("[TB] FAIL clr_valid: got %b expected 00", bus.rd_valid);
        end
        if (bus.valid_count !== 5'd0) begin
            errors++; $display("[TB] FAIL clr_count: got %0d expected 0", bus.valid_count);
        end
        if (bus.rd_data !== 64'h0) begin
            errors++; $display("[TB] FAIL clr_data: got %h expected 0", bus.rd_data);
        end
        clock_cycle();
        checks += 1;
        if (bus.rd_valid[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_no_commit: got %b expected 0", bus.rd_valid[0]);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: AW] = 4'd9;
        bus.wr_data[0 +: WIDTH] = 32'h13572468;
        bus.wr_be[0 +: BE_W] = 4'hF;
        clock_cycle();
        idle_inputs();
        bus.rd_addr[0 +: AW] = 4'd9;
        #1;
        checks += 2;
`ifdef WRITE_BACK_BYPASS_EN
        if (bus.rd_valid[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", bus.rd_valid[0]);
        end
        if (bus.rd_data[0 +: WIDTH] !== 32'h13572468) begin
            errors++; $display("[TB] FAIL bypass_data: got %h expected 13572468", bus.rd_data[0 +: WIDTH]);
        end
`else
        if (bus.rd_valid[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL bypass_valid: got %b expected 0", bus.rd_valid[0]);
        end
        if (bus.rd_data[0 +: WIDTH] !== 32'h0) begin
            errors++; $display("[TB] FAIL bypass_data: got %h expected 0", bus.rd_data[0 +: WIDTH]);
        end
`endif
        clock_cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.wr_en[c] = ($urandom_range(0, 3) != 0);
                bus.wr_addr[c*AW +: AW] = AW'($urandom_range(0, (n % 3 == 0) ? 3 : DEPTH - 1));
                bus.wr_data[c*WIDTH +: WIDTH] = $urandom;
                bus.wr_be[c*BE_W +: BE_W] = BE_W'($urandom_range(0, 15));
            end
            bus.clr = ($urandom_range(0, 24) == 0);
            clock_cycle();
            for (int p = 0; p < NUM_RD; p++) begin
                bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            end
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                logic [31:0] ed;
                logic        ev;
                exp_read(int'(bus.rd_addr[p*AW +: AW]), ed, ev);
                checks += 2;
                if (bus.rd_data[p*WIDTH +: WIDTH] !== ed) begin
                    errors++; $display("[TB] FAIL rand_rd_data[%0d] cyc %0d: got %h expected %h",
                                       p, n, bus.rd_data[p*WIDTH +: WIDTH], ed);
                end
                if (bus.rd_valid[p] !== ev) begin
                    errors++; $display("[TB] FAIL rand_rd_valid[%0d] cyc %0d: got %b expected %b",
                                       p, n, bus.rd_valid[p], ev);
                end
            end
            checks += 2;
            if (int'(bus.valid_count) != m_count) begin
                errors++; $display("[TB] FAIL rand_valid_count cyc %0d: got %0d expected %0d",
                                   n, bus.valid_count, m_count);
            end
            if (bus.conflict !== m_conflict) begin
                errors++; $display("[TB] FAIL rand_conflict cyc %0d: got %b expected %b",
                                   n, bus.conflict, m_conflict);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.wr_en = 2'b11;
        bus.wr_addr = {4'd8, 4'd6};
        bus.wr_data = {32'h88888888, 32'h66666666};
        bus.wr_be = 8'hFF;
        clock_cycle();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
        clock_cycle();
        clock_cycle();
        for (int a = 0; a < DEPTH; a += NUM_RD) begin
            for (int p = 0; p < NUM_RD; p++) bus.rd_addr[p*AW +: AW] = AW'(a + p);
            #1;
            checks += 1;
            if (bus.rd_valid !== 2'b00) begin
                errors++; $display("[TB] FAIL midreset_valid addr %0d: got %b expected 00", a, bus.rd_valid);
            end
        end
        checks += 2;
        if (bus.valid_count !== 5'd0) begin
            errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", bus.valid_count);
        end
        if (bus.conflict !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_conflict: got %b expected 0", bus.conflict);
        end
    endtask

    initial begin
        bus.rd_addr = '0;
        test_reset();
        test_single_write();
        test_collision();
        test_partial();
        test_clr();
        test_bypass();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
